game_ctrl: RTL and testbench

Point/serve/match state machine between the ball/collision path and the two score displays. Watches the ball's left/right miss flags and produces one-cycle score pulses for the score blocks, plus the serve handshake that recentres and releases the ball. Owns the authoritative 4-bit score per player, win detection and game-over. Frame pacing uses the VGA vsync.

---
 rtl/game_ctrl_if.sv | 29 ++
 rtl/game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_game_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and its neighbours (VGA timing,
// ball/collision path, score displays). state_dbg exposes the FSM state.
interface game_ctrl_if;
  logic       vsync;
  logic       start;
  logic       miss_left;
  logic       miss_right;
  logic       score_pulse_p1;
  logic       score_pulse_p2;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       ball_hold;
  logic       serve_dir;
  logic       game_over;
  logic       winner;
  logic [2:0] state_dbg;

  modport master (
    output vsync, start, miss_left, miss_right,
    input  score_pulse_p1, score_pulse_p2, p1_score, p2_score,
           ball_hold, serve_dir, game_over, winner, state_dbg
  );

  modport slave (
    input  vsync, start, miss_left, miss_right,
    output score_pulse_p1, score_pulse_p2, p1_score, p2_score,
           ball_hold, serve_dir, game_over, winner, state_dbg
  );
endinterface

// File: rtl/game_ctrl.sv
// Point/serve/match controller for the pong game. Optional auto-restart after a
// finished match is enabled by defining GAME_CTRL_AUTO_RESTART_EN.
module game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input logic        clk,
  input logic        rst,
  game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  // One counter serves both the serve hold and the game-over hold.
  localparam int CNT_W = $clog2(((SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES) + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES);
  localparam logic [3:0]       WIN_LVL    = 4'(WIN_SCORE);
`ifdef GAME_CTRL_AUTO_RESTART_EN
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES);
`endif

  state_t           state_q, state_d;
  logic [3:0]       p1_q, p1_d, p2_q, p2_d;
  logic             serve_dir_q, serve_dir_d;
  logic             winner_q, winner_d;
  logic             pt_p1_q, pt_p1_d, pt_p2_q, pt_p2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             start_meta_q, start_sync_q, start_prev_q;
  logic             vsync_q;
  logic             start_evt, frame_tick;

  assign start_evt  = start_prev_q & ~start_sync_q;
  assign frame_tick = vsync_q & ~bus.vsync;
  assign cnt_inc    = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      p1_q         <= '0;
      p2_q         <= '0;
      serve_dir_q  <= 1'b1;
      winner_q     <= 1'b0;
      pt_p1_q      <= 1'b0;
      pt_p2_q      <= 1'b0;
      cnt_q        <= '0;
      start_meta_q <= 1'b1;
      start_sync_q <= 1'b1;
      start_prev_q <= 1'b1;
      vsync_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
      pt_p1_q      <= pt_p1_d;
      pt_p2_q      <= pt_p2_d;
      cnt_q        <= cnt_d;
      start_meta_q <= bus.start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
      vsync_q      <= bus.vsync;
    end
  end

  always_comb begin
    state_d     = state_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    pt_p1_d     = pt_p1_q;
    pt_p2_d     = pt_p2_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_evt) begin
          p1_d        = '0;
          p2_d        = '0;
          serve_dir_d = 1'b1;
          cnt_d       = '0;
          state_d     = SERVE;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_inc == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      PLAY: begin
        // Scores move on the edge into POINT so pulse and new score line up.
        if (bus.miss_left || bus.miss_right) begin
          state_d = POINT;
          pt_p1_d = bus.miss_right & ~bus.miss_left;
          pt_p2_d = bus.miss_left & ~bus.miss_right;
          if (bus.miss_left && !bus.miss_right) begin
            p2_d        = p2_q + 4'd1;
            serve_dir_d = 1'b0;
          end else if (bus.miss_right && !bus.miss_left) begin
            p1_d        = p1_q + 4'd1;
            serve_dir_d = 1'b1;
          end
        end
      end
      POINT: begin
        pt_p1_d = 1'b0;
        pt_p2_d = 1'b0;
        cnt_d   = '0;
        if (p1_q == WIN_LVL || p2_q == WIN_LVL) begin
          winner_d = (p2_q == WIN_LVL);
          state_d  = OVER;
        end else begin
          state_d = SERVE;
        end
      end
      OVER: begin
`ifdef GAME_CTRL_AUTO_RESTART_EN
        if (start_evt) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (frame_tick) begin
          if (cnt_inc == OVER_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`else
        if (start_evt) begin
          p1_d        = '0;
          p2_d        = '0;
          serve_dir_d = 1'b1;
          cnt_d       = '0;
          state_d     = SERVE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.score_pulse_p1 = (state_q == POINT) && pt_p1_q;
  assign bus.score_pulse_p2 = (state_q == POINT) && pt_p2_q;
  assign bus.p1_score       = p1_q;
  assign bus.p2_score       = p2_q;
  assign bus.ball_hold      = (state_q != PLAY);
  assign bus.serve_dir      = serve_dir_q;
  assign bus.game_over      = (state_q == OVER);
  assign bus.winner         = winner_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: score pulses go through an expected queue
// checked by a monitor; serve/over timing and reset are checked inline.
module tb_game_ctrl;
  localparam int WIN = 3;
  localparam int SF  = 60;
  localparam int OF  = 4;
  localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_POINT = 3, ST_OVER = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_ctrl_if bus ();

  game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .OVER_FRAMES(OF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_act, mon_exp;
  bit          vs_en = 1'b0;
  int          frame_cnt = 0;

  // vsync: 16-cycle frame, 2-cycle low pulse, counted when driven low
  initial begin
    bus.vsync = 1'b1;
    forever begin
      @(negedge clk);
      if (vs_en) begin
        bus.vsync = 1'b0;
        frame_cnt++;
        repeat (2) @(negedge clk);
        bus.vsync = 1'b1;
        repeat (13) @(negedge clk);
      end
    end
  end

  // monitor: every pulse cycle must match the next expected point
  always @(negedge clk) begin
    if (rst && (bus.score_pulse_p1 || bus.score_pulse_p2)) begin
      mon_act = {bus.score_pulse_p1, bus.score_pulse_p2, bus.p1_score, bus.p2_score, bus.serve_dir};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual %h required none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL score_pulse actual %h required %h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_hold(input logic lvl, input string name);
    int n = 0;
    while (bus.ball_hold !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.ball_hold, lvl);
  endtask

  task automatic miss(input logic l, input logic r, input int cycles);
    @(negedge clk);
    bus.miss_left  = l;
    bus.miss_right = r;
    repeat (cycles) @(negedge clk);
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pulse1"}, bus.score_pulse_p1, 0);
    check({tag, "_pulse2"}, bus.score_pulse_p2, 0);
    check({tag, "_p1"}, bus.p1_score, 0);
    check({tag, "_p2"}, bus.p2_score, 0);
    check({tag, "_hold"}, bus.ball_hold, 1);
    check({tag, "_dir"}, bus.serve_dir, 1);
    check({tag, "_over"}, bus.game_over, 0);
    check({tag, "_winner"}, bus.winner, 0);
    check({tag, "_state"}, bus.state_dbg, ST_IDLE);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start      = 1'b1;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);

    // start held for 1000 cycles gives a single move to SERVE
    bus.start = 1'b0;
    repeat (1000) @(negedge clk);
    check("start_state", bus.state_dbg, ST_SERVE);
    check("start_hold", bus.ball_hold, 1);
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    frame_cnt = 0;
    vs_en = 1'b1;
    wait_hold(1'b0, "serve1_release");
    check("serve_frames", frame_cnt, SF);
    check("play_state", bus.state_dbg, ST_PLAY);

    // miss_right held 500 cycles: one p1 pulse
    exp_q.push_back({1'b1, 1'b0, 4'd1, 4'd0, 1'b1});
    miss(1'b0, 1'b1, 500);
    check("p1pt_state", bus.state_dbg, ST_SERVE);
    check("p1pt_hold", bus.ball_hold, 1);
    check("p1pt_p1", bus.p1_score, 1);
    check("p1pt_dir", bus.serve_dir, 1);
    wait_hold(1'b0, "serve2_release");

    // p2 point flips serve direction
    exp_q.push_back({1'b0, 1'b1, 4'd1, 4'd1, 1'b0});
    miss(1'b1, 1'b0, 3);
    check("p2pt_p2", bus.p2_score, 1);
    check("p2pt_dir", bus.serve_dir, 0);
    wait_hold(1'b0, "serve3_release");

    // simultaneous misses: void point
    @(negedge clk);
    bus.miss_left  = 1'b1;
    bus.miss_right = 1'b1;
    @(negedge clk);
    check("void_point_state", bus.state_dbg, ST_POINT);
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    @(negedge clk);
    check("void_state", bus.state_dbg, ST_SERVE);
    check("void_p1", bus.p1_score, 1);
    check("void_p2", bus.p2_score, 1);
    check("void_dir", bus.serve_dir, 0);
    wait_hold(1'b0, "serve4_release");

    exp_q.push_back({1'b0, 1'b1, 4'd1, 4'd2, 1'b0});
    miss(1'b1, 1'b0, 2);
    wait_hold(1'b0, "serve5_release");
    vs_en = 1'b0;
    repeat (20) @(negedge clk);

    // winning point, then misses held during OVER are ignored
    exp_q.push_back({1'b0, 1'b1, 4'd1, 4'd3, 1'b0});
    bus.miss_left = 1'b1;
    @(negedge clk);
    check("win_point_over", bus.game_over, 0);
    @(negedge clk);
    check("win_state", bus.state_dbg, ST_OVER);
    check("win_over", bus.game_over, 1);
    check("win_winner", bus.winner, 1);
    check("win_hold", bus.ball_hold, 1);
    repeat (20) @(negedge clk);
    bus.miss_left = 1'b0;
    check("over_p1", bus.p1_score, 1);
    check("over_p2", bus.p2_score, 3);

`ifdef GAME_CTRL_AUTO_RESTART_EN
    frame_cnt = 0;
    vs_en = 1'b1;
    n = 0;
    while (bus.game_over && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("auto_over_clear", bus.game_over, 0);
    check("auto_frames", frame_cnt, OF);
    check("auto_state", bus.state_dbg, ST_IDLE);
    check("auto_p1", bus.p1_score, 1);
    check("auto_p2", bus.p2_score, 3);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    check("restart_state", bus.state_dbg, ST_SERVE);
    check("restart_p1", bus.p1_score, 0);
    check("restart_p2", bus.p2_score, 0);
`else
    vs_en = 1'b1;
    repeat (200) @(negedge clk);
    check("held_over", bus.game_over, 1);
    check("held_state", bus.state_dbg, ST_OVER);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    check("restart_state", bus.state_dbg, ST_SERVE);
    check("restart_over", bus.game_over, 0);
    check("restart_p1", bus.p1_score, 0);
    check("restart_p2", bus.p2_score, 0);
    check("restart_dir", bus.serve_dir, 1);
`endif

    // reset during SERVE frame 30
    frame_cnt = 0;
    n = 0;
    while (frame_cnt < 30 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("serve30_frames", frame_cnt, 30);
    check("serve30_hold", bus.ball_hold, 1);
    rst = 1'b0;
    #2;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_state", bus.state_dbg, ST_IDLE);
    check("postrst_hold", bus.ball_hold, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
